// File: rtl/llr_to_out_pkg.sv
// Shared types and helpers for the decoder output stage: LLR type, word
// geometry, FSM states and the saturating magnitude used for weak detection.
package llr_pkg;

  localparam int N_V   = 44;
  localparam int LLR_W = 8;
  localparam int W     = 8;
  localparam int THR   = 1;

  typedef logic signed [LLR_W-1:0] llr_t;

  function automatic int nwords(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

  localparam int NW    = nwords(N_V, W);
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int CNT_W = $clog2(N_V + 1);

  localparam llr_t LLR_MIN = {1'b1, {(LLR_W-1){1'b0}}};
  localparam llr_t LLR_MAX = {1'b0, {(LLR_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  // Most-negative code has no positive twin at LLR_W bits, so clamp it.
  function automatic llr_t llr_abs_sat(input llr_t x);
    llr_t r;
    if (x == LLR_MIN)       r = LLR_MAX;
    else if (x[LLR_W-1])    r = -x;
    else                    r = x;
    return r;
  endfunction

endpackage

// File: rtl/llr_to_out_if.sv
// Input LLR vector handshake plus output codeword word stream, bundled together.
// master = producer/consumer side, slave = the output stage.
interface llr_to_out_if;
  import llr_pkg::*;

  llr_t             llr_in [0:N_V-1];
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out_word;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output llr_in, in_valid, out_ready,
    input  in_ready, out_word, out_idx, out_last, out_valid
  );

  modport slave (
    input  llr_in, in_valid, out_ready,
    output in_ready, out_word, out_idx, out_last, out_valid
  );

endinterface

// File: rtl/llr_to_out_weak_count.sv
// Combinational sign-based hard decision and popcount of low-reliability nodes.
// Zero latency; no flow control.
module llr_weak_count
  import llr_pkg::*;
#(
  parameter int WEAK_THR = THR
) (
  input  llr_t             llr [0:N_V-1],
  output logic [N_V-1:0]   hard,
  output logic [CNT_W-1:0] weak_cnt
);

  localparam llr_t THR_L = llr_t'(WEAK_THR);

  always_comb begin
    hard     = '0;
    weak_cnt = '0;
    for (int i = 0; i < N_V; i++) begin
      hard[i] = ~llr[i][LLR_W-1];
      if (llr_abs_sat(llr[i]) <= THR_L)
        weak_cnt = weak_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/llr_to_out.sv
// Captures a posterior LLR vector, hard-decides it and streams the codeword as W-bit words.
// Accept cycle, one LOAD cycle, then one word per out_ready; input stalls (in_ready=0) until the last word is taken.
module llr_to_out
  import llr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  llr_to_out_if.slave      bus,
  output logic [N_V-1:0]   cw,
  output logic [CNT_W-1:0] weak_cnt,
  output logic             busy
);

  localparam int PAD_W = NW * W;

  state_t           state;
  state_t           state_nxt;
  llr_t             llr_q [0:N_V-1];
  logic [N_V-1:0]   hard;
  logic [CNT_W-1:0] weak_nxt;
  logic [IDX_W-1:0] idx;
  logic [PAD_W-1:0] cw_pad;
  logic             last;

  llr_weak_count #(.WEAK_THR(THR)) u_weak (
    .llr      (llr_q),
    .hard     (hard),
    .weak_cnt (weak_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Zero-extension keeps the pad bits of the final word at 0.
  assign cw_pad = PAD_W'(cw);
  assign last   = (idx == IDX_W'(NW - 1));

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_word  = '0;
    bus.out_idx   = idx;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) state_nxt = LOAD;
      end
      LOAD: state_nxt = STREAM;
      STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last;
        bus.out_word  = cw_pad[idx*W +: W];
        if (bus.out_ready && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pure datapath capture; contents are only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid)
      llr_q <= bus.llr_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cw       <= '0;
      weak_cnt <= '0;
      idx      <= '0;
    end else begin
      if (state == LOAD) begin
        cw       <= hard;
        weak_cnt <= weak_nxt;
        idx      <= '0;
      end else if (state == STREAM && bus.out_ready) begin
        idx <= last ? '0 : idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_llr_to_out.sv
// Directed checks of the LLR output stage: word stream, weak count, stalls, reset abort, back-to-back vectors.
`timescale 1ns/1ps
module tb_llr_to_out;
  import llr_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_V-1:0]   cw;
  logic [CNT_W-1:0] weak_cnt;
  logic             busy;

  llr_to_out_if bus();

  llr_to_out dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .cw       (cw),
    .weak_cnt (weak_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  llr_t vec [0:N_V-1];
  int   waited;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input llr_t v);
    foreach (vec[i]) vec[i] = v;
  endtask

  task automatic run_vec(input string nm, input logic [NW*W-1:0] ew, input logic [N_V-1:0] ecw,
                         input int ewk, input logic hold, input int stall_idx, input int rst_idx,
                         output int wait_n);
    logic [NW*W-1:0] sh;
    logic [W-1:0]    w0;
    int n;
    bus.llr_in    = vec;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    wait_n = n;
    chk({nm, "_accept"}, 64'(n < 40), 64'd1);
    tick();
    if (!hold) bus.in_valid = 1'b0;
    chk({nm, "_load_vld"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "_load_rdy"}, 64'(bus.in_ready), 64'd0);
    tick();
    sh = ew;
    for (int k = 0; k < NW; k++) begin
      w0 = sh[W-1:0];
      chk({nm, "_word"}, 64'(bus.out_word), 64'(w0));
      chk({nm, "_idx"},  64'(bus.out_idx), 64'(k));
      chk({nm, "_last"}, 64'(bus.out_last), 64'(k == NW - 1));
      chk({nm, "_vld"},  64'(bus.out_valid), 64'd1);
      chk({nm, "_rdy"},  64'(bus.in_ready), 64'd0);
      if (k == rst_idx) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk({nm, "_rst_vld"},  64'(bus.out_valid), 64'd0);
        chk({nm, "_rst_last"}, 64'(bus.out_last), 64'd0);
        chk({nm, "_rst_idx"},  64'(bus.out_idx), 64'd0);
        chk({nm, "_rst_rdy"},  64'(bus.in_ready), 64'd1);
        chk({nm, "_rst_cw"},   64'(cw), 64'd0);
        chk({nm, "_rst_weak"}, 64'(weak_cnt), 64'd0);
        return;
      end
      if (k == stall_idx) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        foreach (bus.llr_in[i]) bus.llr_in[i] = LLR_MIN;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk({nm, "_stall_word"}, 64'(bus.out_word), 64'(w0));
          chk({nm, "_stall_idx"},  64'(bus.out_idx), 64'(k));
          chk({nm, "_stall_vld"},  64'(bus.out_valid), 64'd1);
          chk({nm, "_stall_rdy"},  64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
      end
      tick();
      sh = sh >> W;
    end
    chk({nm, "_end_vld"},  64'(bus.out_valid), 64'd0);
    chk({nm, "_end_rdy"},  64'(bus.in_ready), 64'd1);
    chk({nm, "_end_busy"}, 64'(busy), 64'd0);
    chk({nm, "_cw"},       64'(cw), 64'(ecw));
    chk({nm, "_weak"},     64'(weak_cnt), 64'(ewk));
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    fill(llr_t'(0));
    bus.llr_in    = vec;
    tick();
    tick();
    chk("rst_vld",  64'(bus.out_valid), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_idx",  64'(bus.out_idx), 64'd0);
    chk("rst_word", 64'(bus.out_word), 64'd0);
    chk("rst_rdy",  64'(bus.in_ready), 64'd1);
    chk("rst_cw",   64'(cw), 64'd0);
    chk("rst_weak", 64'(weak_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    tick();

    fill(llr_t'(-3));
    run_vec("t1", 48'h0, 44'h0, 0, 1'b0, -1, -1, waited);

    fill(llr_t'(3));
    run_vec("t2", 48'h0F_FFFF_FFFF_FF, 44'hFFF_FFFF_FFFF, 0, 1'b0, -1, -1, waited);

    fill(llr_t'(-5));
    vec[0] = llr_t'(0);
    vec[1] = llr_t'(-1);
    vec[2] = LLR_MIN;
    vec[3] = llr_t'(1);
    run_vec("t3", 48'h00_0000_0000_09, 44'h000_0000_0009, 3, 1'b0, -1, -1, waited);

    foreach (vec[i]) vec[i] = (i % 2 == 0) ? llr_t'(3) : llr_t'(-3);
    run_vec("t4", 48'h05_5555_5555_55, 44'h555_5555_5555, 0, 1'b0, 2, -1, waited);
    tick();
    chk("t4_no_capture_busy", 64'(busy), 64'd0);

    fill(llr_t'(3));
    run_vec("t5", 48'h0F_FFFF_FFFF_FF, 44'hFFF_FFFF_FFFF, 0, 1'b0, -1, 3, waited);

    fill(llr_t'(3));
    run_vec("t6a", 48'h0F_FFFF_FFFF_FF, 44'hFFF_FFFF_FFFF, 0, 1'b1, -1, -1, waited);
    fill(llr_t'(-3));
    run_vec("t6b", 48'h0, 44'h0, 0, 1'b1, -1, -1, waited);
    chk("t6_back2back_wait", 64'(waited), 64'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("t6_idle_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/llr_to_out.md
Name: llr_to_out

Overview:
Output stage of the min-sum decoder and the inverse of the input LLR mapper. It accepts the decoder's final posterior LLR vector over a valid/ready handshake and makes a sign-based hard decision per variable node. It also counts low-reliability nodes. The resulting codeword is streamed to the host as W-bit words over a second valid/ready interface.

Parameters:
N_V, 44, number of variable nodes (codeword length)
LLR_W, 8, signed LLR width (two's complement)
W, 8, output word width in bits
THR, 1, weak-node threshold: node is weak when |llr| <= THR

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  reset, synchronous, active-low
llr_in  input  signed [LLR_W-1:0] x [0:N_V-1]  posterior LLRs from decoder
in_valid  input  1  llr_in valid
in_ready  output  1  block can accept a vector
out_word  output  W  current codeword slice
out_idx  output  $clog2(NW)  index of out_word, where NW = ceil(N_V/W)
out_last  output  1  out_word is the final slice
out_valid  output  1  out_word valid
out_ready  input  1  downstream accepts out_word
cw  output  N_V  full hard-decision vector
weak_cnt  output  $clog2(N_V+1)  number of weak nodes in cw
busy  output  1  state != IDLE

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, in_ready=1.
  - out_valid=0, out_last=0, out_idx=0, out_word=0.
  - cw=0, weak_cnt=0, busy=0.
- Hard decision: cw[i] = ~llr[i][LLR_W-1], so negative LLR gives 0 and LLR >= 0 gives 1. LLR 0 maps to 1.
- Weak detection:
  - |llr| is computed at LLR_W bits; -2^(LLR_W-1) saturates to 2^(LLR_W-1)-1.
  - weak_cnt is the count of nodes with |llr| <= THR.
- FSM, IDLE -> LOAD -> STREAM -> IDLE:
  - IDLE: in_ready=1. On in_valid&&in_ready, register llr_in and go to LOAD.
  - LOAD (1 cycle): in_ready=0. Register cw and weak_cnt from the captured LLRs, set out_idx=0, go to STREAM.
  - STREAM: out_valid=1, out_word = cw[out_idx*W +: W].
    - Bits beyond N_V-1 in the last word are driven 0.
    - out_last = (out_idx==NW-1).
    - On out_valid&&out_ready: if out_last, go to IDLE with out_valid=0 and in_ready=1 next cycle; else out_idx+1.
- Latency: handshake accepted at edge t gives out_valid=1 from the edge at t+2. A vector takes NW+2 cycles minimum to return in_ready=1.
- Handshake rules:
  - out_valid never deasserts without a completed handshake.
  - out_word, out_idx and out_last stay stable while out_valid&&!out_ready.
  - in_valid outside IDLE is ignored; the upstream vector is not consumed.
- cw and weak_cnt hold from LOAD until the next LOAD; they are not cleared on return to IDLE.
- Reset mid-LOAD/STREAM: abort immediately to reset values. There is no partial output and no out_last.
- out_ready asserted while out_valid=0 has no effect.
- Simultaneous final handshake and new in_valid: no new vector is accepted in that cycle (in_ready=0); it is accepted in the following IDLE cycle.

Decomposition:
- Package llr_pkg:
  - LLR_W constant and typedef llr_t = logic signed [LLR_W-1:0].
  - function nwords(n,w) = (n+w-1)/w.
  - function llr_abs_sat(llr_t).
  - FSM state enum {IDLE, LOAD, STREAM}.
- One sub-module, llr_weak_count (combinational): input llr_t vector plus THR, outputs the hard-bit vector and the popcount of weak nodes. The top holds the FSM, capture registers and word mux.

Test Plan:
1. All llr_in=-3, out_ready=1 -> 6 words of 0x00, out_idx 0..5, out_last only on idx 5; weak_cnt=0; out_valid first seen 2 cycles after accept.
2. All llr_in=+3 -> words 0xFF x5 then 0x0F (upper 4 pad bits 0); cw=44'hFFF_FFFF_FFFF; weak_cnt=0.
3. llr[0]=0, llr[1]=-1, llr[2]=-128, llr[3]=+1, rest -5 -> word0=0x09; weak_cnt=3 (nodes 0, 1 and 3); node 2 not weak.
4. out_ready held low 3 cycles at out_idx=2 -> out_word, out_idx and out_valid unchanged for those cycles, then advance to idx 3. in_valid pulsed during STREAM -> in_ready stays 0 and the vector is not captured.
5. rst=0 for one cycle at out_idx=3 -> next cycle out_valid=0, in_ready=1, cw=0, weak_cnt=0; no out_last emitted.
6. Two vectors (all +3, then all -3) with in_valid held high -> second accepted one cycle after the first's out_last handshake; outputs 0xFF.., 0x0F, then 0x00 x6.
